palette_lut: RTL and testbench

//  Upstream video stage: maps the 8-bit Atari colour index (hue[7:4], luma[3:0]) to 24-bit RGB.

---
 rtl/palette_pkg.sv | 38 +++
 rtl/palette_dpram.sv | 26 ++
 rtl/palette_lut.sv | 151 +++++++++++++++
 tb/tb_palette_lut.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup block.
//  NUM_ENTRIES : total RAM depth (both banks)
//  rgb_t       : packed {r,g,b} 24-bit colour
//  state_t     : init / idle for the fill-and-load controller
//  lane_t      : which byte of an R,G,B triplet the loader expects next
package palette_pkg;

  localparam int NUM_BANKS   = 2;
  localparam int BANK_SIZE   = 256;
  localparam int NUM_ENTRIES = NUM_BANKS * BANK_SIZE;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);
  localparam int LUMA_STEP   = 17;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    LANE_R = 2'd0,
    LANE_G = 2'd1,
    LANE_B = 2'd2
  } lane_t;

  // Greyscale ramp entry: luma nibble scaled so 0xF maps to exactly 0xFF.
  function automatic rgb_t grey_rgb(input logic [3:0] luma);
    logic [7:0] v;
    v = 8'(int'(luma) * LUMA_STEP);
    return '{r: v, g: v, b: v};
  endfunction

endpackage

// File: rtl/palette_dpram.sv
// Simple dual-port palette RAM, NUM_ENTRIES x 24.
//  clk          : single clock for both ports
//  we/waddr/wdata : write port
//  re/raddr/rdata : registered read port; rdata holds while re is low
// Same-address read and write in one cycle returns the old contents.
module palette_dpram
  import palette_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rgb_t              wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output rgb_t              rdata
);

  rgb_t mem [NUM_ENTRIES];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/palette_lut.sv
// Atari colour index -> 24-bit RGB lookup with two loadable palettes.
//  clk, reset_n        : clock, synchronous active-low reset
//  ce_pix              : pixel enable; lookup pipeline advances only when high
//  pal, color_in       : bank select and colour index, read address {pal,color_in}
//  hbl/vbl/hs/vs_in    : blank/sync aligned with color_in
//  dl_start/dl_wr/dl_data : byte-serial palette loader (R,G,B per entry)
//  r/g/b_out, *_out    : registered RGB and blank/sync, 2 ce_pix ticks latency
//  init_busy           : greyscale fill in progress
//  dl_overflow         : sticky, byte arrived after the last entry was loaded
module palette_lut
  import palette_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_pix,
  input  logic       pal,
  input  logic [7:0] color_in,
  input  logic       hbl_in,
  input  logic       vbl_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       dl_start,
  input  logic       dl_wr,
  input  logic [7:0] dl_data,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       hbl_out,
  output logic       vbl_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       init_busy,
  output logic       dl_overflow
);

  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(NUM_ENTRIES - 1);

  state_t            state;
  logic [ADDR_W:0]   ptr;       // one extra bit: 512 means "all entries loaded"
  lane_t             lane;
  logic [7:0]        r_lat, g_lat;
  logic              ptr_full;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  rgb_t              wdata;
  rgb_t              q;

  // Blank/sync bundle {hbl,vbl,hs,vs}: stage 1 aligns with the RAM read.
  logic [3:0]        sb_pipe [2:1];
  rgb_t              rgb_o;

  assign ptr_full  = ptr[ADDR_W];
  assign init_busy = (state == ST_INIT);

  // Write port: init fill every clk, or the third byte of a loader triplet.
  // A coincident dl_start wins and drops the byte.
  always_comb begin
    we    = 1'b0;
    waddr = ptr[ADDR_W-1:0];
    wdata = grey_rgb(ptr[3:0]);
    if (reset_n) begin
      if (state == ST_INIT) begin
        we = 1'b1;
      end else if (!dl_start && dl_wr && lane == LANE_B && !ptr_full) begin
        we    = 1'b1;
        wdata = '{r: r_lat, g: g_lat, b: dl_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      ptr         <= '0;
      lane        <= LANE_R;
      r_lat       <= '0;
      g_lat       <= '0;
      dl_overflow <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (ptr == LAST_PTR) begin
            state <= ST_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          if (dl_start) begin
            ptr         <= '0;
            lane        <= LANE_R;
            dl_overflow <= 1'b0;
          end else if (dl_wr) begin
            if (ptr_full) begin
              dl_overflow <= 1'b1;
            end else begin
              case (lane)
                LANE_R: begin
                  r_lat <= dl_data;
                  lane  <= LANE_G;
                end
                LANE_G: begin
                  g_lat <= dl_data;
                  lane  <= LANE_B;
                end
                default: begin
                  ptr  <= ptr + 1'b1;
                  lane <= LANE_R;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  palette_dpram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (ce_pix),
    .raddr ({pal, color_in}),
    .rdata (q)
  );

  // Output stage: blank forces true black so the artifact stage sees 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sb_pipe[1] <= 4'b1100;
      sb_pipe[2] <= 4'b1100;
      rgb_o      <= '0;
    end else if (ce_pix) begin
      sb_pipe[1] <= {hbl_in, vbl_in, hs_in, vs_in};
      sb_pipe[2] <= sb_pipe[1];
      rgb_o      <= (sb_pipe[1][3] || sb_pipe[1][2]) ? '0 : q;
    end
  end

  assign r_out   = rgb_o.r;
  assign g_out   = rgb_o.g;
  assign b_out   = rgb_o.b;
  assign hbl_out = sb_pipe[2][3];
  assign vbl_out = sb_pipe[2][2];
  assign hs_out  = sb_pipe[2][1];
  assign vs_out  = sb_pipe[2][0];

endmodule

// File: tb/tb_palette_lut.sv
// Randomized bench for palette_lut against a behavioural palette model.
module tb_palette_lut;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce_pix = 1'b1;
  logic       pal = 1'b0;
  logic [7:0] color_in = 8'h0;
  logic       hbl_in = 1'b0, vbl_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic       dl_start = 1'b0, dl_wr = 1'b0;
  logic [7:0] dl_data = 8'h0;
  logic [7:0] r_out, g_out, b_out;
  logic       hbl_out, vbl_out, hs_out, vs_out, init_busy, dl_overflow;

  always #5 clk = ~clk;

  palette_lut dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .pal(pal), .color_in(color_in),
    .hbl_in(hbl_in), .vbl_in(vbl_in), .hs_in(hs_in), .vs_in(vs_in),
    .dl_start(dl_start), .dl_wr(dl_wr), .dl_data(dl_data),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hbl_out(hbl_out), .vbl_out(vbl_out), .hs_out(hs_out), .vs_out(vs_out),
    .init_busy(init_busy), .dl_overflow(dl_overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---- behavioural model: palette contents, loader byte queue, 2-tick delay line ----
  logic [23:0] m_mem [512];
  bit          m_known [512];
  bit          m_busy;
  int          m_icnt, m_lptr;
  bit          m_ovf;
  logic [7:0]  pend [$];
  // tick-1 snapshot (what the RAM returned plus the blank/sync seen) and visible outputs
  logic [23:0] s1_rgb;   bit s1_k;   logic [3:0] s1_sb;
  logic [23:0] e_rgb;    bit e_k;    logic [3:0] e_sb;

  task automatic tick();
    int a;
    @(posedge clk);
    if (!reset_n) begin
      m_busy = 1; m_icnt = 0; m_lptr = 0; m_ovf = 0; pend.delete();
      s1_sb = 4'b1100; s1_k = 1;
      e_rgb = 0; e_k = 1; e_sb = 4'b1100;
    end else begin
      if (ce_pix) begin
        e_k   = s1_k || s1_sb[3] || s1_sb[2];
        e_rgb = (s1_sb[3] || s1_sb[2]) ? 24'h0 : s1_rgb;
        e_sb  = s1_sb;
        a = {pal, color_in};
        s1_rgb = m_mem[a]; s1_k = m_known[a];
        s1_sb  = {hbl_in, vbl_in, hs_in, vs_in};
      end
      if (m_busy) begin
        a = (m_icnt % 16) * 17;
        m_mem[m_icnt] = {a[7:0], a[7:0], a[7:0]};
        m_known[m_icnt] = 1;
        m_icnt++;
        if (m_icnt == 512) begin m_busy = 0; m_lptr = 0; end
      end else if (dl_start) begin
        m_lptr = 0; pend.delete(); m_ovf = 0;
      end else if (dl_wr) begin
        if (m_lptr >= 512) m_ovf = 1;
        else begin
          pend.push_back(dl_data);
          if (pend.size() == 3) begin
            m_mem[m_lptr] = {pend[0], pend[1], pend[2]};
            m_known[m_lptr] = 1;
            m_lptr++;
            pend.delete();
          end
        end
      end
    end
    #1;
    if (e_k) chk("rgb", {8'h0, r_out, g_out, b_out}, {8'h0, e_rgb});
    chk("blank_sync", {28'h0, hbl_out, vbl_out, hs_out, vs_out}, {28'h0, e_sb});
    chk("init_busy", {31'h0, init_busy}, {31'h0, m_busy});
    chk("dl_overflow", {31'h0, dl_overflow}, {31'h0, m_ovf});
  endtask

  task automatic send_byte(input logic [7:0] b);
    dl_data = b; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic pulse_start();
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
  endtask

  task automatic look(input logic p, input logic [7:0] c);
    pal = p; color_in = c; ce_pix = 1'b1;
    hbl_in = 0; vbl_in = 0; hs_in = 0; vs_in = 0;
    repeat (3) tick();
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (init_busy && cyc < 700) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    logic [7:0] last [3];
    logic [7:0] b;
    for (int i = 0; i < 512; i++) m_known[i] = 0;

    // Reset, then greyscale fill with a lookup of 0x0A running throughout.
    color_in = 8'h0A;
    repeat (3) tick();
    chk("reset_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
    chk("reset_sb", {28'h0, hbl_out, vbl_out, hs_out, vs_out}, 32'hC);
    reset_n = 1'b1;
    wait_init(cyc);
    chk("init_len", cyc, 512);
    repeat (2) tick();
    chk("grey_0A", {8'h0, r_out, g_out, b_out}, 32'h00AAAAAA);

    // Single entry load into bank 0 entry 0; bank 1 untouched.
    pulse_start();
    send_byte(8'h12); tick(); send_byte(8'h34); send_byte(8'h56);
    look(0, 8'h00);
    chk("entry0_load", {8'h0, r_out, g_out, b_out}, 32'h00123456);
    look(1, 8'h00);
    chk("bank1_e0", {8'h0, r_out, g_out, b_out}, 32'h0);

    // Full load of 1536 bytes plus one extra -> overflow.
    pulse_start();
    for (int i = 0; i < 1536; i++) begin
      b = 8'($urandom);
      last[i % 3] = b;
      pal = 1'($urandom); color_in = 8'($urandom);
      send_byte(b);
    end
    chk("no_ovf_yet", {31'h0, dl_overflow}, 32'h0);
    send_byte(8'h77);
    chk("ovf_set", {31'h0, dl_overflow}, 32'h1);
    look(1, 8'hFF);
    chk("entry511", {8'h0, r_out, g_out, b_out}, {8'h0, last[0], last[1], last[2]});
    pulse_start();
    chk("ovf_clr", {31'h0, dl_overflow}, 32'h0);

    // Partial triplet discarded by restart.
    send_byte(8'h01); send_byte(8'h02);
    pulse_start();
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
    look(0, 8'h00);
    chk("partial_drop", {8'h0, r_out, g_out, b_out}, 32'h00FF0000);

    // Blanking forces black.
    pal = 0; color_in = 8'h0F; hbl_in = 1;
    repeat (3) tick();
    chk("hbl_black", {8'h0, r_out, g_out, b_out}, 32'h0);
    chk("hbl_out", {31'h0, hbl_out}, 32'h1);

    // ce_pix 1-in-4 with random lookups and blank/sync.
    for (int i = 0; i < 240; i++) begin
      ce_pix = (i % 4 == 0);
      pal = 1'($urandom); color_in = 8'($urandom);
      hbl_in = ($urandom_range(0, 5) == 0); vbl_in = ($urandom_range(0, 7) == 0);
      hs_in = 1'($urandom); vs_in = 1'($urandom);
      tick();
    end

    // Random mix of lookups and loader traffic, incl. start+wr collisions.
    for (int i = 0; i < 800; i++) begin
      ce_pix = 1'($urandom);
      pal = 1'($urandom); color_in = 8'($urandom_range(0, 15));
      hbl_in = ($urandom_range(0, 7) == 0); vbl_in = 0;
      hs_in = 1'($urandom); vs_in = 1'($urandom);
      dl_start = ($urandom_range(0, 40) == 0);
      dl_wr = 1'($urandom); dl_data = 8'($urandom);
      tick();
    end
    dl_start = 0; dl_wr = 0;

    // Reset mid-load: init restarts and refills greyscale.
    pulse_start();
    for (int i = 0; i < 100; i++) send_byte(8'($urandom));
    reset_n = 1'b0;
    tick();
    chk("reinit_busy", {31'h0, init_busy}, 32'h1);
    reset_n = 1'b1;
    wait_init(cyc);
    chk("reinit_len", cyc, 512);
    look(0, 8'h03);
    chk("grey_refill", {8'h0, r_out, g_out, b_out}, 32'h00333333);
    pulse_start();
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    look(0, 8'h00);
    chk("reload_e0", {8'h0, r_out, g_out, b_out}, 32'h00A1B2C3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
